reservoir_plant_model: RTL and testbench
========================================

Name: reservoir_plant_model

Overview:
- Behavioural-synthesizable model of the water reservoir that the flow-rate controller drives.
- Consumes the controller's valve commands (fr2, fr1, fr0, dfr) and a configurable drain rate.
- Integrates the net flow into a level register and produces the 3-bit thermometer sensor vector s[2:0] that feeds back to the controller.
- Closes the loop for system-level simulation and on-FPGA demos.

Parameters:
- LEVEL_W, 10, width of the level accumulator.
- MAX_LEVEL, 1023, saturation ceiling; must be at most 2^LEVEL_W-1.
- T1, 256, level at or above which s[0] asserts.
- T2, 512, level at or above which s[1] asserts.
- T3, 768, level at or above which s[2] asserts; T1<T2<T3 required.
- TICK_DIV, 4, clock cycles per integration tick; at least 1.
- RESET_LEVEL, 0, level value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fr0  in  1  valve 0 open, weight 1 unit/tick
- fr1  in  1  valve 1 open, weight 2 units/tick
- fr2  in  1  valve 2 open, weight 4 units/tick
- dfr  in  1  supplemental valve open, weight 8 units/tick
- drain  in  4  outflow in units/tick, 0..15
- ld_en  in  1  test load strobe
- ld_val  in  LEVEL_W  level value to load
- s  out  3  sensor thermometer vector, registered
- level  out  LEVEL_W  current level, registered
- tick  out  1  one-cycle pulse on each integration cycle
- full  out  1  sticky flag; level hit MAX_LEVEL with positive net flow
- dry  out  1  sticky flag; level hit 0 with negative net flow

Behaviour:
- Reset values: clk and reset are as already decided (reset: synchronous, active-high; clock: clk). On reset, level=RESET_LEVEL, s=thermometer(RESET_LEVEL), tick=0, full=0, dry=0, prescaler=0. Reset mid-tick discards any pending integration.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Inflow = fr0*1 + fr1*2 + fr2*4 + dfr*8, range 0..15. Net = inflow - drain, signed 6-bit, range -15..+15.
- On a tick cycle, at the clock edge, level <= sat(level+net):
  - Computed in LEVEL_W+2 signed arithmetic.
  - Clamped to 0..MAX_LEVEL.
  - If the unclamped sum exceeds MAX_LEVEL, level=MAX_LEVEL and full is set.
  - If the unclamped sum is below 0, level=0 and dry is set.
  - Landing exactly on 0 or MAX_LEVEL does not set a flag.
- Inputs are sampled only on tick cycles. Valve changes between ticks have no effect.
- Load:
  - ld_en=1 forces level <= min(ld_val, MAX_LEVEL) at the next edge.
  - Load takes priority over a coincident tick.
  - The prescaler is unaffected.
  - full and dry are not cleared.
- Sensor stage:
  - s is registered from level: s[0]=(level>=T1), s[1]=(level>=T2), s[2]=(level>=T3).
  - s lags level by exactly one cycle.
  - s is always thermometer-coded (000, 001, 011, 111).
- Sensor state machine, one per threshold band:
  - States are BAND0, BAND1, BAND2, BAND3, encoded as s 000/001/011/111.
  - Transitions follow level. A band may jump by more than one step only after a load.
  - Band encoding is shared with the controller's sensor semantics.
- full and dry clear only on reset.

Optional Feature:
- Macro RESERVOIR_HYST_EN.
- When defined:
  - Each threshold comparator has hysteresis HYST=8 units.
  - A sensor bit rises when level>=Tn.
  - It falls only when level<Tn-HYST.
  - Between those points it holds its prior value.
  - On reset, bits are computed without hysteresis.
- When undefined: pure comparisons as above. Sensor bits may toggle on every tick while level sits at a threshold under balanced flow.

Decomposition:
- Package reservoir_pkg holds:
  - typedef level_t, logic [LEVEL_W-1:0]
  - localparams W_FR0=1, W_FR1=2, W_FR2=4, W_DFR=8
  - HYST=8
  - the band encoding constants
- One sub-module, reservoir_sensor: threshold compare, optional hysteresis, s register.
- The integrator, prescaler and flags stay in the top module.

Test Plan:
- Reset, all four valves=1, drain=0: inflow is 15/tick. After 18 ticks (72 cycles), level=270. s goes 000->001 in the cycle after level crosses 256.
- Load 1020, all valves=1, drain=0, one tick: level=1023, full=1, s=111. Further ticks hold 1023.
- Load 5, all valves=0, drain=15, one tick: level=0, dry=1, s=000. Flags persist until reset.
- Load 510, fr1=1 only, drain=0: one tick gives level=512 and s=011 one cycle later. Set drain=2: level holds at 512.
- ld_en coincident with tick, ld_val=100, net=+15: level=100, not 115.
- With RESERVOIR_HYST_EN, load 256 then s=001. Drain to 250: s stays 001. Drain to 247: s=000. Without the macro, s=000 at 255.

Source files
------------

// File: rtl/reservoir_pkg.sv
// -----------------------------------------------------------------------------
// reservoir_pkg
// Shared types and constants for the reservoir plant model.
//   level_t           default-width level type
//   W_FR0..W_DFR      inflow weight of each valve, units per tick
//   HYST              comparator hysteresis used when RESERVOIR_HYST_EN is set
//   band_e            sensor band encoding; identical to the s[2:0] thermometer
//                     code the flow-rate controller interprets
// -----------------------------------------------------------------------------
package reservoir_pkg;

    localparam int DEF_LEVEL_W = 10;

    typedef logic [DEF_LEVEL_W-1:0] level_t;

    localparam int W_FR0 = 1;
    localparam int W_FR1 = 2;
    localparam int W_FR2 = 4;
    localparam int W_DFR = 8;

    localparam int HYST = 8;

    // Each band value is the s[2:0] vector seen by the controller.
    typedef enum logic [2:0] {
        BAND0 = 3'b000,
        BAND1 = 3'b001,
        BAND2 = 3'b011,
        BAND3 = 3'b111
    } band_e;

endpackage

// File: rtl/reservoir_plant_model_if.sv
// -----------------------------------------------------------------------------
// reservoir_plant_model_if
// Bundle between the flow-rate controller (master) and the reservoir plant
// (slave).
//   fr0, fr1, fr2, dfr   valve commands from the controller
//   drain[3:0]           outflow in units per tick
//   ld_en, ld_val        test load of the level register
//   s[2:0]               thermometer sensor vector back to the controller
//   level                current level
//   tick                 integration-cycle pulse
//   full, dry            sticky overflow / underflow flags
// -----------------------------------------------------------------------------
interface reservoir_plant_model_if #(
    parameter int LEVEL_W = 10
) ();

    logic               fr0;
    logic               fr1;
    logic               fr2;
    logic               dfr;
    logic [3:0]         drain;
    logic               ld_en;
    logic [LEVEL_W-1:0] ld_val;
    logic [2:0]         s;
    logic [LEVEL_W-1:0] level;
    logic               tick;
    logic               full;
    logic               dry;

    modport master (
        output fr0, fr1, fr2, dfr, drain, ld_en, ld_val,
        input  s, level, tick, full, dry
    );

    modport slave (
        input  fr0, fr1, fr2, dfr, drain, ld_en, ld_val,
        output s, level, tick, full, dry
    );

endinterface

// File: rtl/reservoir_sensor.sv
// -----------------------------------------------------------------------------
// reservoir_sensor
// Threshold comparators and the registered band state that drives s[2:0].
// Optional macro: RESERVOIR_HYST_EN adds HYST units of hysteresis to each
// comparator (bit rises at level>=Tn, falls only at level<Tn-HYST).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   level        registered level from the integrator
//   band         registered band state (thermometer code), one cycle behind level
// -----------------------------------------------------------------------------
module reservoir_sensor
    import reservoir_pkg::*;
#(
    parameter int LEVEL_W     = 10,
    parameter int T1          = 256,
    parameter int T2          = 512,
    parameter int T3          = 768,
    parameter int RESET_LEVEL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    output band_e              band
);

    // Reset band is a plain comparison of the reset level, never hysteretic.
    localparam logic [2:0] RST_BITS = {(RESET_LEVEL >= T3),
                                       (RESET_LEVEL >= T2),
                                       (RESET_LEVEL >= T1)};

    band_e      band_q;
    band_e      band_d;
    logic [2:0] bit_d;
    logic [2:0] band_bits;

    assign band_bits = band_q;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
        localparam int TN = (gi == 0) ? T1 : ((gi == 1) ? T2 : T3);
        localparam logic [LEVEL_W-1:0] TN_HI = LEVEL_W'(TN);
`ifdef RESERVOIR_HYST_EN
        localparam logic [LEVEL_W-1:0] TN_LO = LEVEL_W'(TN - HYST);
        // A set bit stays set until the level drops below the lower point.
        assign bit_d[gi] = band_bits[gi] ? (level >= TN_LO) : (level >= TN_HI);
`else
        assign bit_d[gi] = (level >= TN_HI);
`endif
    end

    // Thresholds are ordered, so bit_d is always a valid thermometer code.
    always_comb begin
        band_d = band_e'(bit_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            band_q <= band_e'(RST_BITS);
        end else begin
            band_q <= band_d;
        end
    end

    assign band = band_q;

endmodule

// File: rtl/reservoir_plant_model.sv
// -----------------------------------------------------------------------------
// reservoir_plant_model
// Synthesizable model of the reservoir driven by the flow-rate controller.
// A prescaler produces an integration tick every TICK_DIV cycles; on each tick
// the net flow (weighted valve inflow minus drain) is added to the level with
// saturation at 0 and MAX_LEVEL, setting sticky dry/full flags on overshoot.
// A test load overrides the level. The sensor sub-module turns the level into
// the s[2:0] thermometer vector.
// Optional macro: RESERVOIR_HYST_EN (sensor hysteresis, see reservoir_sensor).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          reservoir_plant_model_if slave modport (valves, drain, load in;
//                s, level, tick, full, dry out)
// -----------------------------------------------------------------------------
module reservoir_plant_model
    import reservoir_pkg::*;
#(
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int MAX_LEVEL   = 1023,
    parameter int T1          = 256,
    parameter int T2          = 512,
    parameter int T3          = 768,
    parameter int TICK_DIV    = 4,
    parameter int RESET_LEVEL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    reservoir_plant_model_if.slave  bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int SUM_W = LEVEL_W + 2;
    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] RST_L = LEVEL_W'(RESET_LEVEL);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tick_q, tick_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic                    full_q, full_d;
    logic                    dry_q, dry_d;

    logic [4:0]              inflow;
    logic signed [5:0]       net;
    logic signed [SUM_W-1:0] sum;
    band_e                   band;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        // tick is registered: it is high while the count sits at its last value.
        tick_d = (cnt_d == CNT_LAST);

        inflow = (bus.fr0 ? 5'(W_FR0) : 5'd0)
               + (bus.fr1 ? 5'(W_FR1) : 5'd0)
               + (bus.fr2 ? 5'(W_FR2) : 5'd0)
               + (bus.dfr ? 5'(W_DFR) : 5'd0);
        net = $signed({1'b0, inflow}) - $signed({2'b00, bus.drain});
        // Two guard bits hold both the MAX_LEVEL+15 overshoot and the sign.
        sum = $signed({2'b00, level_q}) + SUM_W'(net);

        level_d = level_q;
        full_d  = full_q;
        dry_d   = dry_q;

        if (bus.ld_en) begin
            // Load wins over a coincident tick; flags are left untouched.
            level_d = (bus.ld_val > MAX_L) ? MAX_L : bus.ld_val;
        end else if (tick_q) begin
            if (sum > MAX_S) begin
                level_d = MAX_L;
                full_d  = 1'b1;
            end else if (sum < 0) begin
                level_d = '0;
                dry_d   = 1'b1;
            end else begin
                level_d = sum[LEVEL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= RST_L;
            full_q  <= 1'b0;
            dry_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            full_q  <= full_d;
            dry_q   <= dry_d;
        end
    end

    reservoir_sensor #(
        .LEVEL_W     (LEVEL_W),
        .T1          (T1),
        .T2          (T2),
        .T3          (T3),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sensor (
        .clk   (clk),
        .reset (reset),
        .level (level_q),
        .band  (band)
    );

    assign bus.s     = band;
    assign bus.level = level_q;
    assign bus.tick  = tick_q;
    assign bus.full  = full_q;
    assign bus.dry   = dry_q;

endmodule

// File: tb/tb_reservoir_plant_model.sv
// -----------------------------------------------------------------------------
// tb_reservoir_plant_model
// Directed stimulus with a behavioural reservoir model checked every cycle,
// plus literal expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_reservoir_plant_model;

    localparam int LW   = 10;
    localparam int MAXL = 1023;
    localparam int T1   = 256;
    localparam int T2   = 512;
    localparam int T3   = 768;
    localparam int TD   = 4;
    localparam int RL   = 0;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reservoir_plant_model_if #(.LEVEL_W(LW)) bus ();

    reservoir_plant_model #(
        .LEVEL_W     (LW),
        .MAX_LEVEL   (MAXL),
        .T1          (T1),
        .T2          (T2),
        .T3          (T3),
        .TICK_DIV    (TD),
        .RESET_LEVEL (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_level;
    int         m_edges;   // non-reset edges since the last reset
    bit         m_full;
    bit         m_dry;
    bit         m_valid = 1'b0;
    logic [2:0] m_s;

    function automatic logic [2:0] therm(input int lvl);
        return {(lvl >= T3), (lvl >= T2), (lvl >= T1)};
    endfunction

    function automatic logic [2:0] sense(input int lvl, input logic [2:0] prev);
        logic [2:0] r;
        int th [3];
        th[0] = T1; th[1] = T2; th[2] = T3;
        for (int i = 0; i < 3; i++) begin
`ifdef RESERVOIR_HYST_EN
            r[i] = prev[i] ? (lvl >= th[i] - 8) : (lvl >= th[i]);
`else
            r[i] = (lvl >= th[i]) && (prev[i] | ~prev[i]);
`endif
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int prev_level;
        int sum;
        if (reset) begin
            m_level = RL;
            m_edges = 0;
            m_full  = 1'b0;
            m_dry   = 1'b0;
            m_s     = therm(RL);
            m_valid = 1'b1;
        end else begin
            prev_level = m_level;
            if (bus.ld_en) begin
                m_level = (int'(bus.ld_val) > MAXL) ? MAXL : int'(bus.ld_val);
            end else if (m_edges % TD == TD - 1) begin
                sum = m_level + int'(bus.fr0) + 2 * int'(bus.fr1)
                    + 4 * int'(bus.fr2) + 8 * int'(bus.dfr) - int'(bus.drain);
                if (sum > MAXL) begin
                    m_level = MAXL;
                    m_full  = 1'b1;
                end else if (sum < 0) begin
                    m_level = 0;
                    m_dry   = 1'b1;
                end else begin
                    m_level = sum;
                end
            end
            m_edges++;
            m_s = sense(prev_level, m_s);
        end
        #1;
        if (m_valid) begin
            check("cyc_level", int'(bus.level), m_level);
            check("cyc_tick",  int'(bus.tick), (m_edges % TD == TD - 1) ? 1 : 0);
            check("cyc_full",  int'(bus.full), int'(m_full));
            check("cyc_dry",   int'(bus.dry),  int'(m_dry));
            check("cyc_s",     int'(bus.s),    int'(m_s));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_flow(input bit f0, input bit f1, input bit f2,
                            input bit fd, input int dr);
        bus.fr0   = f0;
        bus.fr1   = f1;
        bus.fr2   = f2;
        bus.dfr   = fd;
        bus.drain = 4'(dr);
    endtask

    task automatic load(input int v);
        bus.ld_en  = 1'b1;
        bus.ld_val = LW'(v);
        @(negedge clk);
        bus.ld_en  = 1'b0;
    endtask

    // Advance to the negedge just after the next tick edge.
    task automatic wait_tick();
        for (int k = 0; k < 3 * TD && bus.tick !== 1'b1; k++) @(negedge clk);
        check("tick_seen", int'(bus.tick === 1'b1), 1);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        bus.ld_en  = 1'b0;
        bus.ld_val = '0;
        set_flow(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_level", int'(bus.level), 0);
        check("rst_s",     int'(bus.s), 0);
        check("rst_tick",  int'(bus.tick), 0);
        check("rst_full",  int'(bus.full), 0);
        check("rst_dry",   int'(bus.dry), 0);

        // Fill at 15/tick: 18 ticks in 72 cycles.
        reset = 1'b0;
        set_flow(1, 1, 1, 1, 0);
        repeat (72) @(negedge clk);
        check("fill_level", int'(bus.level), 270);
        check("fill_s_lag", int'(bus.s), 3'b000);
        @(negedge clk);
        check("fill_s", int'(bus.s), 3'b001);

        // Overflow saturates and sets full.
        load(1020);
        wait_tick();
        check("ovf_level", int'(bus.level), 1023);
        check("ovf_full",  int'(bus.full), 1);
        @(negedge clk);
        check("ovf_s", int'(bus.s), 3'b111);
        wait_tick();
        check("ovf_hold", int'(bus.level), 1023);

        // Underflow saturates and sets dry; full persists.
        set_flow(0, 0, 0, 0, 15);
        load(5);
        wait_tick();
        check("udf_level", int'(bus.level), 0);
        check("udf_dry",   int'(bus.dry), 1);
        @(negedge clk);
        check("udf_s",     int'(bus.s), 3'b000);
        check("udf_full",  int'(bus.full), 1);

        // Cross T2 exactly, then balance flow.
        set_flow(0, 1, 0, 0, 0);
        load(510);
        wait_tick();
        check("t2_level", int'(bus.level), 512);
        @(negedge clk);
        check("t2_s", int'(bus.s), 3'b011);
        bus.drain = 4'd2;
        wait_tick();
        check("bal_level", int'(bus.level), 512);

        // Load coincident with a tick wins.
        for (int k = 0; k < 3 * TD && bus.tick !== 1'b1; k++) @(negedge clk);
        check("coin_tick", int'(bus.tick === 1'b1), 1);
        set_flow(1, 1, 1, 1, 0);
        load(100);
        check("coin_level", int'(bus.level), 100);

        // Comparator behaviour around T1.
        set_flow(0, 0, 0, 0, 0);
        load(256);
        @(negedge clk);
        check("t1_s_set", int'(bus.s), 3'b001);
`ifdef RESERVOIR_HYST_EN
        load(250);
        @(negedge clk);
        check("hyst_hold", int'(bus.s), 3'b001);
        load(247);
        @(negedge clk);
        check("hyst_fall", int'(bus.s), 3'b000);
`else
        load(255);
        @(negedge clk);
        check("t1_s_fall", int'(bus.s), 3'b000);
`endif

        // Reset clears sticky flags.
        reset = 1'b1;
        @(negedge clk);
        check("rst2_full",  int'(bus.full), 0);
        check("rst2_dry",   int'(bus.dry), 0);
        check("rst2_level", int'(bus.level), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
